updown_counter_param: RTL

//  Parametrised successor to the 3-bit up counter: WIDTH-bit synchronous
//  up/down counter with modulo limit, parallel load, enable and

---
 rtl/updown_counter_param.sv | 80 ++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// WIDTH-bit synchronous up/down counter with modulo limit, clamped parallel load,
// wrap or saturate at the limits, a Gray-coded view and a registered terminal-count pulse.
module updown_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2 ** WIDTH - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_gray_o,
    output logic             tc_o
);

    localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

    if (WIDTH < 2) begin : g_width_chk
        $error("updown_counter_param: WIDTH must be at least 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2 ** WIDTH - 1) begin : g_max_chk
        $error("updown_counter_param: MAX_VAL out of range for WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] next_ext;
    logic           at_max;
    logic           at_zero;

    // Next-state arithmetic is one bit wider so the limit compare never aliases.
    assign cnt_ext  = {1'b0, count_q};
    assign load_ext = {1'b0, load_val_i};
    assign inc_ext  = cnt_ext + 1'b1;
    assign dec_ext  = cnt_ext - 1'b1;
    assign at_max   = (cnt_ext >= MaxExt);
    assign at_zero  = (count_q == '0);

    always_comb begin
        next_ext = cnt_ext;
        tc_d     = 1'b0;
        if (load_i) begin
            next_ext = (load_ext > MaxExt) ? MaxExt : load_ext;
        end else if (en_i) begin
            if (up_dn_i) begin
                tc_d     = at_max;
                next_ext = at_max ? (SATURATE ? MaxExt : '0) : inc_ext;
            end else begin
                tc_d     = at_zero;
                next_ext = at_zero ? (SATURATE ? '0 : MaxExt) : dec_ext;
            end
        end
        // Final guard keeps the register inside 0..MAX_VAL under any input.
        count_d = (next_ext > MaxExt) ? MaxVal : next_ext[WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o      = count_q;
    assign count_gray_o = count_q ^ (count_q >> 1);
    assign tc_o         = tc_q;

endmodule
